// File: rtl/ibex_pmp_csr.sv
// PMP CSR file: pmpcfg0-3, pmpaddr0-15, mseccfg; registered views for the PMP checker.
// Optional IBEX_PMP_SHADOW_EN keeps inverted shadow copies and flags mismatches on shadow_err_o.
package ibex_pmp_csr_pkg;
    typedef enum logic [1:0] {
        PMP_OFF   = 2'd0,
        PMP_TOR   = 2'd1,
        PMP_NA4   = 2'd2,
        PMP_NAPOT = 2'd3
    } pmp_mode_t;

    typedef struct packed {
        logic      lock;
        pmp_mode_t mode;
        logic      exec;
        logic      write;
        logic      read;
    } pmp_cfg_t;

    typedef struct packed {
        logic rlb;
        logic mmwp;
        logic mml;
    } pmp_mseccfg_t;

    localparam int PMP_ADDR_MSB = 33;
endpackage

module ibex_pmp_csr
    import ibex_pmp_csr_pkg::*;
#(
    parameter int PMPGranularity = 0,
    parameter int PMPNumRegions  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  csr_we_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [31:0]           csr_wdata_i,
    output logic                  csr_addr_hit_o,
    output logic [31:0]           csr_rdata_o,
    output pmp_cfg_t              csr_pmp_cfg_o [PMPNumRegions],
    output logic [PMP_ADDR_MSB:0] csr_pmp_addr_o [PMPNumRegions],
    output pmp_mseccfg_t          csr_pmp_mseccfg_o,
    output logic                  pmp_upd_o,
    output logic                  shadow_err_o
);
    localparam int N = PMPNumRegions;
    localparam int G = PMPGranularity;

    pmp_cfg_t     cfg_q  [N];
    pmp_cfg_t     cfg_d  [N];
    logic [31:0]  addr_q [N];
    logic [31:0]  addr_d [N];
    pmp_mseccfg_t msec_q, msec_d;
    logic         pmp_upd_q, pmp_upd_d;

    logic         cfg_sel, addr_sel, msec_sel, msech_sel;
    logic [N-1:0] locked;
    logic [N:0]   tor_lock;
    logic         any_lock;
    logic [7:0]   wb;

    assign cfg_sel   = csr_addr_i[11:2] == 10'h0E8;
    assign addr_sel  = csr_addr_i[11:4] == 8'h3B;
    assign msec_sel  = csr_addr_i == 12'h747;
    assign msech_sel = csr_addr_i == 12'h757;
    assign csr_addr_hit_o = cfg_sel | addr_sel | msec_sel | msech_sel;

    function automatic pmp_cfg_t cfg_warl(logic l, logic [4:0] lo, logic mml);
        pmp_cfg_t c;
        c.lock  = l;
        c.mode  = pmp_mode_t'(lo[4:3]);
        c.exec  = lo[2];
        c.read  = lo[0];
        c.write = lo[1] & (lo[0] | mml);
        if (G > 0 && c.mode == PMP_NA4) c.mode = PMP_OFF;
        return c;
    endfunction

    function automatic logic [31:0] addr_rd(logic [31:0] a, pmp_mode_t m);
        logic [31:0] r;
        r = a;
        for (int b = 0; b < 32; b++) begin
            if (G >= 2 && m == PMP_NAPOT && b <= G - 2) r[b] = 1'b1;
            if (G >= 1 && (m == PMP_OFF || m == PMP_TOR) && b < G) r[b] = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        locked   = '0;
        tor_lock = '0;
        any_lock = 1'b0;
        for (int i = 0; i < N; i++) begin
            locked[i]   = cfg_q[i].lock & ~msec_q.rlb;
            tor_lock[i] = locked[i] & (cfg_q[i].mode == PMP_TOR);
            any_lock    = any_lock | cfg_q[i].lock;
        end
    end

    always_comb begin
        msec_d    = msec_q;
        pmp_upd_d = 1'b0;
        wb        = '0;
        for (int i = 0; i < N; i++) begin
            cfg_d[i]  = cfg_q[i];
            addr_d[i] = addr_q[i];
        end
        if (csr_we_i) begin
            for (int i = 0; i < N; i++) begin
                wb = csr_wdata_i[8*(i%4) +: 8];
                // MML forbids creating locked executable or write-only rules
                if (cfg_sel && csr_addr_i[1:0] == 2'(i / 4) && !locked[i] &&
                    !(msec_q.mml && !msec_q.rlb && wb[7] &&
                      (wb[2] || (wb[1] && !wb[0]))))
                    cfg_d[i] = cfg_warl(wb[7], wb[4:0], msec_q.mml);
                if (addr_sel && csr_addr_i[3:0] == 4'(i) && !locked[i] &&
                    !tor_lock[i+1])
                    addr_d[i] = csr_wdata_i;
            end
            if (msec_sel) begin
                msec_d.mml  = msec_q.mml | csr_wdata_i[0];
                msec_d.mmwp = msec_q.mmwp | csr_wdata_i[1];
                if (msec_q.rlb || !any_lock) msec_d.rlb = csr_wdata_i[2];
            end
        end
        for (int i = 0; i < N; i++)
            pmp_upd_d = pmp_upd_d | (cfg_d[i] != cfg_q[i]) | (addr_d[i] != addr_q[i]);
        pmp_upd_d = pmp_upd_d | (msec_d != msec_q);
    end

    always_comb begin
        csr_rdata_o = '0;
        for (int i = 0; i < N; i++) begin
            if (cfg_sel && csr_addr_i[1:0] == 2'(i / 4))
                csr_rdata_o[8*(i%4) +: 8] = {cfg_q[i].lock, 2'b00, cfg_q[i].mode,
                                             cfg_q[i].exec, cfg_q[i].write, cfg_q[i].read};
            if (addr_sel && csr_addr_i[3:0] == 4'(i))
                csr_rdata_o = addr_rd(addr_q[i], cfg_q[i].mode);
        end
        if (msec_sel) csr_rdata_o = {29'b0, msec_q};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
            msec_q    <= '0;
            pmp_upd_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                cfg_q[i]  <= cfg_d[i];
                addr_q[i] <= addr_d[i];
            end
            msec_q    <= msec_d;
            pmp_upd_q <= pmp_upd_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_out
        assign csr_pmp_cfg_o[i]  = cfg_q[i];
        assign csr_pmp_addr_o[i] = {addr_q[i], 2'b00};
    end
    assign csr_pmp_mseccfg_o = msec_q;
    assign pmp_upd_o         = pmp_upd_q;

`ifdef IBEX_PMP_SHADOW_EN
    pmp_cfg_t     cfg_sh_q  [N];
    logic [31:0]  addr_sh_q [N];
    pmp_mseccfg_t msec_sh_q;
    logic         shadow_err_q, shadow_err_d;

    always_comb begin
        shadow_err_d = shadow_err_q | (msec_q != ~msec_sh_q);
        for (int i = 0; i < N; i++)
            shadow_err_d = shadow_err_d | (cfg_q[i] != ~cfg_sh_q[i]) |
                           (addr_q[i] != ~addr_sh_q[i]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                cfg_sh_q[i]  <= '1;
                addr_sh_q[i] <= '1;
            end
            msec_sh_q    <= '1;
            shadow_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                cfg_sh_q[i]  <= ~cfg_d[i];
                addr_sh_q[i] <= ~addr_d[i];
            end
            msec_sh_q    <= ~msec_d;
            shadow_err_q <= shadow_err_d;
        end
    end
    assign shadow_err_o = shadow_err_q;
`else
    assign shadow_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_ibex_pmp_csr.sv
// Scoreboard bench for ibex_pmp_csr: random CSR traffic against an
// architectural model of the PMP registers, plus directed corner sequences.
module tb_ibex_pmp_csr;
    import ibex_pmp_csr_pkg::*;

    localparam int NR = 4;
    localparam int G  = 0;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        we = 1'b0;
    logic [11:0] a = '0;
    logic [31:0] wd = '0;
    logic        hit, upd, serr;
    logic [31:0] rdata;
    pmp_cfg_t    cfg_o [NR];
    logic [33:0] addr_o [NR];
    pmp_mseccfg_t msec_o;

    ibex_pmp_csr #(.PMPGranularity(G), .PMPNumRegions(NR)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .csr_we_i(we), .csr_addr_i(a),
        .csr_wdata_i(wd), .csr_addr_hit_o(hit), .csr_rdata_o(rdata),
        .csr_pmp_cfg_o(cfg_o), .csr_pmp_addr_o(addr_o),
        .csr_pmp_mseccfg_o(msec_o), .pmp_upd_o(upd), .shadow_err_o(serr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]          rdata;
        logic                 hit;
        logic                 upd;
        logic [2:0]           msec;
        logic [NR-1:0][5:0]   cfg;
        logic [NR-1:0][33:0]  addr;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;

    logic [7:0]  m_cfg [16];
    logic [31:0] m_addr [16];
    logic        m_mml, m_mmwp, m_rlb, upd_prev;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_cfg[i] = '0;
            m_addr[i] = '0;
        end
        m_mml = 0; m_mmwp = 0; m_rlb = 0; upd_prev = 0;
    endfunction

    function automatic bit m_lk(int i);
        return i < NR && m_cfg[i][7] && !m_rlb;
    endfunction

    function automatic bit m_hit(logic [11:0] ad);
        return (ad >= 12'h3A0 && ad <= 12'h3A3) || ad[11:4] == 8'h3B ||
               ad == 12'h747 || ad == 12'h757;
    endfunction

    function automatic logic [31:0] m_read(logic [11:0] ad);
        logic [31:0] r;
        int i;
        int sh1;
        r = '0;
        sh1 = (G >= 2) ? G - 1 : 0;
        if (ad >= 12'h3A0 && ad <= 12'h3A3) begin
            for (int k = 0; k < 4; k++) begin
                i = int'(ad - 12'h3A0) * 4 + k;
                if (i < NR) r[8*k +: 8] = m_cfg[i];
            end
        end else if (ad[11:4] == 8'h3B) begin
            i = int'(ad[3:0]);
            if (i < NR) begin
                r = m_addr[i];
                if (m_cfg[i][4:3] == 2'b11 && G >= 2) r = r | ((32'd1 << sh1) - 1);
                if (m_cfg[i][4:3] <= 2'b01 && G >= 1) r = r & ~((32'd1 << G) - 1);
            end
        end else if (ad == 12'h747) begin
            r = {29'b0, m_rlb, m_mmwp, m_mml};
        end
        return r;
    endfunction

    function automatic bit m_write(logic [11:0] ad, logic [31:0] d);
        bit ch;
        bit any_l;
        logic [7:0] b, nb;
        logic [2:0] old;
        int i;
        ch = 0;
        if (ad >= 12'h3A0 && ad <= 12'h3A3) begin
            for (int k = 0; k < 4; k++) begin
                i = int'(ad - 12'h3A0) * 4 + k;
                b = d[8*k +: 8];
                if (i >= NR || m_lk(i)) continue;
                if (m_mml && !m_rlb && b[7] && (b[2] || (b[1] && !b[0]))) continue;
                nb = b & 8'h9F;
                if (!b[0] && b[1] && !m_mml) nb[1] = 1'b0;
                if (G > 0 && nb[4:3] == 2'b10) nb[4:3] = 2'b00;
                if (nb != m_cfg[i]) ch = 1;
                m_cfg[i] = nb;
            end
        end else if (ad[11:4] == 8'h3B) begin
            i = int'(ad[3:0]);
            if (i < NR && !m_lk(i) &&
                !(i + 1 < NR && m_lk(i + 1) && m_cfg[i+1][4:3] == 2'b01)) begin
                ch = m_addr[i] != d;
                m_addr[i] = d;
            end
        end else if (ad == 12'h747) begin
            old = {m_rlb, m_mmwp, m_mml};
            any_l = 0;
            for (int j = 0; j < NR; j++) any_l = any_l | m_cfg[j][7];
            m_mml = m_mml | d[0];
            m_mmwp = m_mmwp | d[1];
            if (m_rlb || !any_l) m_rlb = d[2];
            ch = old != {m_rlb, m_mmwp, m_mml};
        end
        return ch;
    endfunction

    task automatic issue(logic w, logic [11:0] ad, logic [31:0] d);
        exp_t e;
        @(negedge clk);
        we = w; a = ad; wd = d;
        e.rdata = m_read(ad);
        e.hit = m_hit(ad);
        e.upd = upd_prev;
        e.msec = {m_rlb, m_mmwp, m_mml};
        for (int i = 0; i < NR; i++) begin
            e.cfg[i] = {m_cfg[i][7], m_cfg[i][4:0]};
            e.addr[i] = {m_addr[i], 2'b00};
        end
        sb.push_back(e);
        upd_prev = w ? m_write(ad, d) : 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        we = 0;
        rst_ni = 0;
        m_reset();
        @(negedge clk);
        rst_ni = 1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) chk("drain_timeout", 64'(sb.size()), 0);
    endtask

    task automatic episode(int n, bit rlb_first);
        logic [11:0] ad;
        logic [31:0] d;
        logic w;
        int r;
        do_reset();
        if (rlb_first) issue(1, 12'h747, 32'h4);
        repeat (n) begin
            r = $urandom_range(0, 9);
            w = $urandom_range(0, 3) != 0;
            d = $urandom;
            if (r <= 2) begin
                ad = ($urandom_range(0, 3) != 0) ? 12'h3A0 : 12'h3A0 + 12'($urandom_range(0, 3));
                for (int k = 0; k < 4; k++) d[8*k+7] = $urandom_range(0, 7) == 0;
            end else if (r <= 6) begin
                ad = 12'h3B0 + 12'($urandom_range(0, 5));
            end else if (r == 7) begin
                ad = 12'h747;
                d[0] = $urandom_range(0, 5) == 0;
                d[1] = $urandom_range(0, 5) == 0;
            end else if (r == 8) begin
                case ($urandom_range(0, 3))
                    0: ad = 12'h757;
                    1: ad = 12'h3A4;
                    2: ad = 12'h3C0;
                    default: ad = 12'($urandom);
                endcase
            end else begin
                ad = 12'h3A0 + 12'($urandom_range(0, 31));
                w = 0;
            end
            issue(w, ad, d);
        end
        drain();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("addr_hit", hit, e.hit);
                chk("pmp_upd", upd, e.upd);
                chk("mseccfg", msec_o, e.msec);
                chk("shadow_err", serr, 0);
                for (int i = 0; i < NR; i++) begin
                    chk($sformatf("cfg%0d", i), cfg_o[i], e.cfg[i]);
                    chk($sformatf("addr%0d", i), addr_o[i], e.addr[i]);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        m_reset();
        do_reset();
        issue(0, 12'h3A0, 0);
        issue(0, 12'h3B0, 0);
        issue(0, 12'h747, 0);
        issue(1, 12'h3A0, 32'h0000_001F);
        issue(1, 12'h3B0, 32'h0000_01FF);
        issue(0, 12'h3A0, 0);
        #3;
        chk("napot_cfg0", cfg_o[0], 6'h1F);
        chk("napot_addr0", addr_o[0], 34'h7FC);
        chk("napot_upd", upd, 1);
        issue(1, 12'h3A0, 32'h0000_8F00);
        issue(1, 12'h3B0, 32'h0000_1234);
        issue(1, 12'h3B1, 32'h0000_5678);
        issue(0, 12'h3B0, 0);
        issue(0, 12'h3B0, 0);
        #3;
        chk("tor_lock_upd", upd, 0);
        chk("tor_lock_addr0", addr_o[0], 34'h7FC);
        issue(1, 12'h3A1, 32'hFFFF_FFFF);
        issue(1, 12'h3B5, 32'hFFFF_FFFF);
        issue(0, 12'h3A1, 0);
        drain();

        do_reset();
        issue(1, 12'h3A0, 32'h02);
        issue(1, 12'h747, 32'h1);
        issue(1, 12'h3A0, 32'h84);
        issue(1, 12'h747, 32'h0);
        issue(0, 12'h747, 0);
        #3;
        chk("mml_sticky", msec_o, 3'b001);
        chk("mml_lock_x_blocked", cfg_o[0], 6'h00);
        drain();

        do_reset();
        issue(1, 12'h3A0, 32'h80);
        issue(1, 12'h747, 32'h4);
        issue(0, 12'h747, 0);
        #3;
        chk("rlb_held", msec_o, 3'b000);
        do_reset();
        issue(1, 12'h747, 32'h4);
        issue(1, 12'h3A0, 32'h80);
        issue(1, 12'h3A0, 32'h03);
        issue(0, 12'h3A0, 0);
        #3;
        chk("rlb_set", msec_o, 3'b100);
        chk("rlb_cfg_writable", cfg_o[0], 6'h03);
        drain();

        do_reset();
        @(negedge clk);
        we = 1; a = 12'h3B0; wd = 32'hDEAD_BEEF;
        #2 rst_ni = 0;
        m_reset();
        @(negedge clk);
        we = 0;
        rst_ni = 1;
        issue(0, 12'h3B0, 0);
        issue(0, 12'h3B0, 0);
        drain();

        episode(250, 0);
        episode(250, 1);
        episode(250, 0);

`ifdef IBEX_PMP_SHADOW_EN
        do_reset();
        @(negedge clk);
        force dut.msec_sh_q = 3'b000;
        @(negedge clk);
        release dut.msec_sh_q;
        #3;
        chk("shadow_err_set", serr, 1);
        repeat (3) @(negedge clk);
        #3;
        chk("shadow_err_sticky", serr, 1);
        rst_ni = 0;
        #3;
        chk("shadow_err_reset", serr, 0);
        @(negedge clk);
        rst_ni = 1;
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
